// File: rtl/tlc_signal_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_signal_monitor
//  Description : Receive-side conflict monitor for the traffic light
//                controller. Watches the highway and farm light codes every
//                clock. It checks for conflicts, invalid codes, illegal colour
//                sequences and yellow / all-red / green timing violations.
//                The first violation seen while armed latches a fault code
//                and raises FlashReq so the top level can force flashing red.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_signal_monitor #(
    parameter int unsigned CW         = 31,
    parameter int unsigned MIN_YELLOW = 150000000,
    parameter int unsigned MIN_ALLRED = 50000000,
    parameter int unsigned MAX_GREEN  = 1600000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       FaultClr,
    output logic       Armed,
    output logic       Fault,
    output logic [2:0] FaultCode,
    output logic       FlashReq,
    output logic [1:0] monState
);

    // Light encoding shared by both approaches
    localparam logic [1:0] c_GREEN   = 2'b00;
    localparam logic [1:0] c_YELLOW  = 2'b01;
    localparam logic [1:0] c_RED     = 2'b10;
    localparam logic [1:0] c_INVALID = 2'b11;

    // Timing limits sized to the counter width. The green limit gets one
    // extra bit because it is compared against count + 1.
    localparam logic [CW-1:0] c_CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] c_MIN_YELLOW = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] c_MIN_ALLRED = CW'(MIN_ALLRED);
    localparam logic [CW:0]   c_MAX_GREEN  = (CW+1)'(MAX_GREEN);

    typedef enum logic [1:0] {
        ST_ARM     = 2'b00,
        ST_RUN     = 2'b01,
        ST_FAULT   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    faultCode_q, faultCode_d;
    logic [1:0]    hwPrev_q, fmPrev_q;
    logic [CW-1:0] hwCnt_q, hwCnt_d;
    logic [CW-1:0] fmCnt_q, fmCnt_d;
    logic [CW-1:0] allRedCnt_q, allRedCnt_d;

    logic          hwChanged, fmChanged, bothRed;
    logic [CW:0]   hwGreenLen, fmGreenLen;
    logic [2:0]    checkCode;

    // A change is legal only along green -> yellow -> red -> green
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        return (prev == cur) ||
               (prev == c_GREEN  && cur == c_YELLOW) ||
               (prev == c_YELLOW && cur == c_RED)    ||
               (prev == c_RED    && cur == c_GREEN);
    endfunction

    // Hold counter: restart at 1 on a change, otherwise count up and saturate
    function automatic logic [CW-1:0] hold_next(input logic changed, input logic [CW-1:0] cnt);
        if (changed) begin
            return CW'(1);
        end else if (cnt == c_CNT_MAX) begin
            return cnt;
        end else begin
            return cnt + CW'(1);
        end
    endfunction

    assign hwChanged = (highwaySignal != hwPrev_q);
    assign fmChanged = (farmSignal != fmPrev_q);
    assign bothRed   = (highwaySignal == c_RED) && (farmSignal == c_RED);

    // Green length including the current cycle (1 on the first green cycle)
    assign hwGreenLen = hwChanged ? (CW+1)'(1) : ({1'b0, hwCnt_q} + (CW+1)'(1));
    assign fmGreenLen = fmChanged ? (CW+1)'(1) : ({1'b0, fmCnt_q} + (CW+1)'(1));

    // Evaluate all rules on the current inputs; the lowest code has priority
    always_comb begin
        checkCode = 3'd0;
        if (highwaySignal != c_RED && farmSignal != c_RED) begin
            checkCode = 3'd1;
        end else if (highwaySignal == c_INVALID || farmSignal == c_INVALID) begin
            checkCode = 3'd2;
        end else if (!legal_step(hwPrev_q, highwaySignal) || !legal_step(fmPrev_q, farmSignal)) begin
            checkCode = 3'd3;
        end else if ((hwPrev_q == c_YELLOW && highwaySignal == c_RED && hwCnt_q < c_MIN_YELLOW) ||
                     (fmPrev_q == c_YELLOW && farmSignal == c_RED && fmCnt_q < c_MIN_YELLOW)) begin
            checkCode = 3'd4;
        end else if (((hwPrev_q == c_RED && highwaySignal == c_GREEN) ||
                      (fmPrev_q == c_RED && farmSignal == c_GREEN)) &&
                     allRedCnt_q < c_MIN_ALLRED) begin
            checkCode = 3'd5;
        end else if ((highwaySignal == c_GREEN && hwGreenLen > c_MAX_GREEN) ||
                     (farmSignal == c_GREEN && fmGreenLen > c_MAX_GREEN)) begin
            checkCode = 3'd6;
        end
    end

    // Duration counters run in every state so timing is valid right after arming
    always_comb begin
        hwCnt_d = hold_next(hwChanged, hwCnt_q);
        fmCnt_d = hold_next(fmChanged, fmCnt_q);
        if (state_q == ST_ARM && bothRed) begin
            allRedCnt_d = CW'(1);
        end else if (bothRed) begin
            allRedCnt_d = (allRedCnt_q == c_CNT_MAX) ? allRedCnt_q : allRedCnt_q + CW'(1);
        end else begin
            allRedCnt_d = '0;
        end
    end

    // Monitor FSM next state and sticky fault code
    always_comb begin
        state_d     = state_q;
        faultCode_d = faultCode_q;
        case (state_q)
            ST_ARM: begin
                if (bothRed) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (checkCode != 3'd0) begin
                    state_d     = ST_FAULT;
                    faultCode_d = checkCode;
                end
            end
            ST_FAULT: begin
                if (FaultClr) begin
                    state_d     = ST_ARM;
                    faultCode_d = 3'd0;
                end
            end
            default: begin
                state_d     = ST_ARM;
                faultCode_d = 3'd0;
            end
        endcase
    end

    // State, history and counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_ARM;
            faultCode_q <= 3'd0;
            hwPrev_q    <= c_RED;
            fmPrev_q    <= c_RED;
            hwCnt_q     <= '0;
            fmCnt_q     <= '0;
            allRedCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            faultCode_q <= faultCode_d;
            hwPrev_q    <= highwaySignal;
            fmPrev_q    <= farmSignal;
            hwCnt_q     <= hwCnt_d;
            fmCnt_q     <= fmCnt_d;
            allRedCnt_q <= allRedCnt_d;
        end
    end

    assign Armed     = (state_q == ST_RUN);
    assign Fault     = (state_q == ST_FAULT);
    assign FlashReq  = Fault;
    assign FaultCode = faultCode_q;
    assign monState  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tlc_signal_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlc_signal_monitor
//  Description : Self-checking bench for tlc_signal_monitor. A behavioural
//                model tracks mode, fault code and run lengths as integers.
//                Directed sequences plus random light traffic are compared
//                against it on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_signal_monitor;

    localparam int CW         = 4;
    localparam int MIN_YELLOW = 4;
    localparam int MIN_ALLRED = 2;
    localparam int MAX_GREEN  = 10;
    localparam int SAT        = (1 << CW) - 1;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [1:0] highwaySignal = R;
    logic [1:0] farmSignal = R;
    logic       FaultClr = 1'b0;
    logic       Armed, Fault, FlashReq;
    logic [2:0] FaultCode;
    logic [1:0] monState;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: mode 0 = arm, 1 = run, 2 = fault
    int         m_mode = 0;
    int         m_code = 0;
    logic [1:0] m_hwPrev = R;
    logic [1:0] m_fmPrev = R;
    int         m_hwHeld = 0;
    int         m_fmHeld = 0;
    int         m_allRed = 0;

    tlc_signal_monitor #(
        .CW        (CW),
        .MIN_YELLOW(MIN_YELLOW),
        .MIN_ALLRED(MIN_ALLRED),
        .MAX_GREEN (MAX_GREEN)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .highwaySignal(highwaySignal),
        .farmSignal   (farmSignal),
        .FaultClr     (FaultClr),
        .Armed        (Armed),
        .Fault        (Fault),
        .FaultCode    (FaultCode),
        .FlashReq     (FlashReq),
        .monState     (monState)
    );

    always #5 Clk = ~Clk;

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Colours advance cyclically G(0) -> Y(1) -> R(2) -> G
    function automatic bit step_ok(input logic [1:0] p, input logic [1:0] c);
        if (p == c) return 1'b1;
        if (p == X || c == X) return 1'b0;
        return int'(c) == ((int'(p) + 1) % 3);
    endfunction

    function automatic int rule_code(input logic [1:0] hw, input logic [1:0] fm);
        bit r [1:6];
        int hwLen, fmLen;
        hwLen = (hw == m_hwPrev) ? m_hwHeld + 1 : 1;
        fmLen = (fm == m_fmPrev) ? m_fmHeld + 1 : 1;
        r[1] = (hw != R) && (fm != R);
        r[2] = (hw == X) || (fm == X);
        r[3] = !step_ok(m_hwPrev, hw) || !step_ok(m_fmPrev, fm);
        r[4] = (m_hwPrev == Y && hw == R && m_hwHeld < MIN_YELLOW) ||
               (m_fmPrev == Y && fm == R && m_fmHeld < MIN_YELLOW);
        r[5] = ((m_hwPrev == R && hw == G) || (m_fmPrev == R && fm == G)) && (m_allRed < MIN_ALLRED);
        r[6] = (hw == G && hwLen > MAX_GREEN) || (fm == G && fmLen > MAX_GREEN);
        for (int c = 1; c <= 6; c++) if (r[c]) return c;
        return 0;
    endfunction

    task automatic model_update(input logic [1:0] hw, input logic [1:0] fm, input logic clr, input logic rst);
        int  v;
        int  hwNext, fmNext, arNext;
        bit  bothRed;
        if (rst) begin
            m_mode = 0; m_code = 0; m_hwPrev = R; m_fmPrev = R;
            m_hwHeld = 0; m_fmHeld = 0; m_allRed = 0;
            return;
        end
        bothRed = (hw == R) && (fm == R);
        v       = (m_mode == 1) ? rule_code(hw, fm) : 0;
        hwNext  = (hw == m_hwPrev) ? sat(m_hwHeld + 1) : 1;
        fmNext  = (fm == m_fmPrev) ? sat(m_fmHeld + 1) : 1;
        arNext  = !bothRed ? 0 : (m_mode == 0) ? 1 : sat(m_allRed + 1);
        if (m_mode == 0) begin
            if (bothRed) m_mode = 1;
        end else if (m_mode == 1) begin
            if (v != 0) begin m_mode = 2; m_code = v; end
        end else begin
            if (clr) begin m_mode = 0; m_code = 0; end
        end
        m_hwHeld = hwNext; m_fmHeld = fmNext; m_allRed = arNext;
        m_hwPrev = hw;     m_fmPrev = fm;
    endtask

    // One clock: drive inputs, advance model at the edge, return 1 time unit after
    task automatic step(input logic [1:0] hw, input logic [1:0] fm, input logic clr, input logic rst);
        highwaySignal = hw;
        farmSignal    = fm;
        FaultClr      = clr;
        Rst           = rst;
        @(posedge Clk);
        model_update(hw, fm, clr, rst);
        #1;
    endtask

    task automatic hold(input logic [1:0] hw, input logic [1:0] fm, input int n);
        for (int i = 0; i < n; i++) step(hw, fm, 1'b0, 1'b0);
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic legal_cycle();
        hold(R, R, 3);
        hold(G, R, 5);
        hold(Y, R, 4);
        hold(R, R, 1);
        hold(R, R, 2);
        hold(R, G, 5);
        hold(R, Y, 4);
        hold(R, R, 1);
    endtask

    function automatic logic [1:0] next_col(input logic [1:0] c);
        return (c == G) ? Y : (c == Y) ? R : G;
    endfunction

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                n_tests++;
                if (Armed !== (m_mode == 1) || Fault !== (m_mode == 2) || FlashReq !== (m_mode == 2) ||
                    FaultCode !== 3'(m_code) || monState !== 2'(m_mode)) begin
                    n_fail++;
                    $display("FAIL cycle_cmp @%0t: got Armed=%b Fault=%b FlashReq=%b FaultCode=%0d monState=%0d, expected mode=%0d code=%0d",
                             $time, Armed, Fault, FlashReq, FaultCode, monState, m_mode, m_code);
                end
            end
        end
    end

    initial begin
        logic [1:0] gh, gf;
        int         r;
        bit         clr, rst;

        // Reset
        step(R, R, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(R, R, 1'b0, 1'b1);
        check_lit("reset_state", monState, 0);
        check_lit("reset_fault", Fault, 0);
        check_lit("reset_code", FaultCode, 0);

        // Legal cycle twice, no gaps
        hold(R, R, 1);
        check_lit("t1_armed_2nd", Armed, 1);
        hold(R, R, 2);
        hold(G, R, 5); hold(Y, R, 4); hold(R, R, 3);
        hold(R, G, 5); hold(R, Y, 4); hold(R, R, 1);
        legal_cycle();
        check_lit("t1_nofault", Fault, 0);
        check_lit("t1_armed", Armed, 1);
        // FaultClr while running has no effect
        step(R, R, 1'b1, 1'b0);
        check_lit("clr_in_run", monState, 1);

        // Conflict
        step(G, Y, 1'b0, 1'b0);
        check_lit("t2_code", FaultCode, 1);
        check_lit("t2_flash", FlashReq, 1);
        check_lit("t2_armed", Armed, 0);
        step(R, R, 1'b1, 1'b0);
        check_lit("t6_clr_fault", Fault, 0);
        check_lit("t6_clr_state", monState, 0);
        step(R, R, 1'b0, 1'b0);
        check_lit("t6_rearm", monState, 1);

        // Short yellow, then exact minimum yellow
        hold(R, R, 1); hold(G, R, 2); hold(Y, R, 3);
        step(R, R, 1'b0, 1'b0);
        check_lit("t3_short_yellow", FaultCode, 4);
        step(R, R, 1'b1, 1'b0);
        hold(R, R, 2); hold(G, R, 2); hold(Y, R, 4);
        step(R, R, 1'b0, 1'b0);
        check_lit("t3_min_yellow_ok", Fault, 0);

        // Illegal transition, invalid code
        hold(R, R, 1);
        step(G, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        check_lit("t4_illegal", FaultCode, 3);
        step(R, R, 1'b1, 1'b0);
        step(R, R, 1'b0, 1'b0);
        step(R, X, 1'b0, 1'b0);
        check_lit("t4_invalid", FaultCode, 2);

        // Short all-red, green timeout, sticky code
        step(R, R, 1'b1, 1'b0);
        step(R, R, 1'b0, 1'b0);
        step(G, R, 1'b0, 1'b0);
        check_lit("t5_short_allred", FaultCode, 5);
        step(R, R, 1'b1, 1'b0);
        hold(R, R, 3);
        hold(G, R, 10);
        check_lit("t5_green10_ok", Fault, 0);
        step(G, R, 1'b0, 1'b0);
        check_lit("t5_green_timeout", FaultCode, 6);
        step(X, X, 1'b0, 1'b0);
        check_lit("t5_sticky", FaultCode, 6);

        // Rst wins over FaultClr
        step(R, R, 1'b1, 1'b1);
        check_lit("t6_rst_state", monState, 0);
        check_lit("t6_rst_code", FaultCode, 0);

        // Saturating counters must not wrap
        hold(R, R, 1); hold(R, R, 16);
        hold(G, R, 3); hold(Y, R, 18);
        step(R, R, 1'b0, 1'b0);
        check_lit("sat_no_wrap", Fault, 0);

        // Random traffic
        gh = R; gf = R;
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(0, 99));
            clr = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if (r < 10)       gh = next_col(gh);
            else if (r < 20)  gf = next_col(gf);
            else if (r < 22)  gh = 2'($urandom_range(0, 3));
            else if (r < 24)  gf = 2'($urandom_range(0, 3));
            else if (r < 28) begin gh = R; gf = R; end
            step(gh, gf, clr, rst);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
